// File: rtl/crossbar_route_ctl_if.sv
// ----------------------------------------------------------------------------
// crossbar_route_ctl_if
//   Bundles the configuration handshake, the frame-control inputs and the
//   crossbar-facing outputs of crossbar_route_ctl.
//
//   Handshake: a route map (or rotate request) is transferred on a rising
//   clock edge where cfg_ready_out=1 and cfg_valid_in=1 (or rot_req_in=1).
//   cfg_ready_out does not depend on cfg_valid_in; the controller raises it
//   only while idle. A map that fails the permutation check is consumed
//   (cfg_err_out pulses on the next cycle) rather than held off.
//
//   modport slave  : used by the controller
//   modport master : used by the host / frame sequencer side
// ----------------------------------------------------------------------------
interface crossbar_route_ctl_if;
  logic       cfg_valid_in;
  logic       cfg_ready_out;
  logic [7:0] cfg_map_in;
  logic       rot_req_in;
  logic       abort_in;
  logic       frame_sync_in;
  logic [1:0] xbar_selectors_a_out;
  logic [1:0] xbar_selectors_b_out;
  logic [1:0] xbar_selectors_c_out;
  logic [1:0] xbar_selectors_d_out;
  logic       xbar_blank_out;
  logic       pending_out;
  logic       cfg_err_out;

  modport slave (
    input  cfg_valid_in, cfg_map_in, rot_req_in, abort_in, frame_sync_in,
    output cfg_ready_out, xbar_selectors_a_out, xbar_selectors_b_out,
           xbar_selectors_c_out, xbar_selectors_d_out, xbar_blank_out,
           pending_out, cfg_err_out
  );

  modport master (
    output cfg_valid_in, cfg_map_in, rot_req_in, abort_in, frame_sync_in,
    input  cfg_ready_out, xbar_selectors_a_out, xbar_selectors_b_out,
           xbar_selectors_c_out, xbar_selectors_d_out, xbar_blank_out,
           pending_out, cfg_err_out
  );
endinterface

// File: rtl/crossbar_route_ctl.sv
// ----------------------------------------------------------------------------
// crossbar_route_ctl
//   Owns the four 2-bit source selectors of a 4x4 crossbar output mux.
//   New route maps (or a rotation of the live map) are held in a shadow
//   register and committed to the live selectors only on a frame boundary;
//   the datapath is then blanked for SETTLE_CYCLES cycles.
//
// Ports
//   clk_in         : clock, rising edge
//   rst_n_in       : asynchronous active-low reset, synchronous release
//   bus            : crossbar_route_ctl_if.slave (config handshake, frame
//                    control, live selectors, blank/pending/error status)
//   state_dbg_out  : current FSM state (0 IDLE, 1 PENDING, 2 BLANK)
//
// Map layout: [1:0]=a, [3:2]=b, [5:4]=c, [7:6]=d.
// ----------------------------------------------------------------------------
module crossbar_route_ctl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          REQUIRE_PERM  = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  crossbar_route_ctl_if.slave   bus,
  output logic [1:0]            state_dbg_out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_BLANK   = 2'd2
  } state_e;

  localparam logic [7:0] IDENTITY_MAP = 8'b11_10_01_00;
  // Guarded so SETTLE_CYCLES=0 does not produce an out-of-range load value.
  localparam logic [3:0] SETTLE_LOAD  =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] live_q,   live_d;
  logic [7:0] shadow_q, shadow_d;
  logic [3:0] cnt_q,    cnt_d;
  logic       err_q,    err_d;

  logic       map_legal;
  logic [7:0] rot_map;

  // A map is legal when no two outputs pick the same input (or always, when
  // fan-out is allowed).
  always_comb begin
    map_legal = 1'b1;
    if (REQUIRE_PERM) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = i + 1; j < 4; j++) begin
          if (bus.cfg_map_in[2*i +: 2] == bus.cfg_map_in[2*j +: 2]) begin
            map_legal = 1'b0;
          end
        end
      end
    end
  end

  // new a = old b, b = c, c = d, d = a
  assign rot_map = {live_q[1:0], live_q[7:6], live_q[5:4], live_q[3:2]};

  // State and datapath registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_IDLE;
      live_q   <= IDENTITY_MAP;
      shadow_q <= IDENTITY_MAP;
      cnt_q    <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    live_d   = live_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // cfg beats rotate; frame_sync has no effect here.
        if (bus.cfg_valid_in) begin
          if (map_legal) begin
            shadow_d = bus.cfg_map_in;
            state_d  = ST_PENDING;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.rot_req_in) begin
          shadow_d = rot_map;
          state_d  = ST_PENDING;
        end
      end
      ST_PENDING: begin
        // abort beats frame_sync; the shadow is simply left stale.
        if (bus.abort_in) begin
          state_d = ST_IDLE;
        end else if (bus.frame_sync_in) begin
          live_d = shadow_q;
          cnt_d  = SETTLE_LOAD;
          state_d = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_BLANK;
        end
      end
      ST_BLANK: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: all derived from registers, so selectors update together.
  always_comb begin
    bus.cfg_ready_out        = (state_q == ST_IDLE);
    bus.pending_out          = (state_q == ST_PENDING);
    bus.xbar_blank_out       = (state_q == ST_BLANK);
    bus.cfg_err_out          = err_q;
    bus.xbar_selectors_a_out = live_q[1:0];
    bus.xbar_selectors_b_out = live_q[3:2];
    bus.xbar_selectors_c_out = live_q[5:4];
    bus.xbar_selectors_d_out = live_q[7:6];
    state_dbg_out            = state_q;
  end

endmodule

// File: tb/tb_crossbar_route_ctl.sv
module tb_crossbar_route_ctl;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  crossbar_route_ctl_if if0 ();
  crossbar_route_ctl_if if1 ();
  logic [1:0] dbg0, dbg1;

  // Main instance: blanking 2 cycles, permutations enforced.
  crossbar_route_ctl #(.SETTLE_CYCLES(2), .REQUIRE_PERM(1'b1)) u_dut0 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if0.slave), .state_dbg_out(dbg0));
  // Second instance: fan-out allowed, no blanking.
  crossbar_route_ctl #(.SETTLE_CYCLES(0), .REQUIRE_PERM(1'b0)) u_dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .bus(if1.slave), .state_dbg_out(dbg1));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_map;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] live0();
    return {if0.xbar_selectors_d_out, if0.xbar_selectors_c_out,
            if0.xbar_selectors_b_out, if0.xbar_selectors_a_out};
  endfunction

  function automatic logic [7:0] live1();
    return {if1.xbar_selectors_d_out, if1.xbar_selectors_c_out,
            if1.xbar_selectors_b_out, if1.xbar_selectors_a_out};
  endfunction

  // Reference legality: count how often each input is used.
  function automatic logic model_legal(input logic [7:0] m);
    int cnt[4];
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    for (int k = 0; k < 4; k++) cnt[m[2*k +: 2]]++;
    for (int k = 0; k < 4; k++) if (cnt[k] > 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic sb_check(input string tag, input logic [7:0] obs);
    check_eq({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) check_eq(tag, obs, exp_q.pop_front());
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Drive one cycle of cfg (optionally with rot/frame_sync) on instance 0.
  task automatic send_map(input logic [7:0] m, input logic rot, input logic fs);
    if0.cfg_valid_in = 1'b1; if0.cfg_map_in = m;
    if0.rot_req_in = rot; if0.frame_sync_in = fs;
    @(negedge clk_in);
    if0.cfg_valid_in = 1'b0; if0.rot_req_in = 1'b0; if0.frame_sync_in = 1'b0;
  endtask

  task automatic send_rot();
    if0.rot_req_in = 1'b1;
    @(negedge clk_in);
    if0.rot_req_in = 1'b0;
  endtask

  task automatic do_sync(input string tag, input logic [7:0] exp_map);
    exp_q.push_back(exp_map);
    if0.frame_sync_in = 1'b1;
    @(negedge clk_in);
    if0.frame_sync_in = 1'b0;
    sb_check(tag, live0());
    cur_map = exp_map;
  endtask

  initial begin
    logic [7:0] m;
    logic legal;
    if0.cfg_valid_in = 0; if0.cfg_map_in = 0; if0.rot_req_in = 0;
    if0.abort_in = 0; if0.frame_sync_in = 0;
    if1.cfg_valid_in = 0; if1.cfg_map_in = 0; if1.rot_req_in = 0;
    if1.abort_in = 0; if1.frame_sync_in = 0;
    cur_map = 8'hE4;
    idle(3);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Reset state
    check_eq("rst_sel", live0(), 8'hE4);
    check_eq("rst_ready", if0.cfg_ready_out, 1);
    check_eq("rst_blank", if0.xbar_blank_out, 0);
    check_eq("rst_pending", if0.pending_out, 0);
    check_eq("rst_err", if0.cfg_err_out, 0);

    // Map accepted, frame_sync 5 cycles later, 2 blank cycles
    send_map(8'h1B, 1'b0, 1'b0);
    check_eq("acc_pending", if0.pending_out, 1);
    check_eq("acc_ready", if0.cfg_ready_out, 0);
    check_eq("acc_live_hold", live0(), 8'hE4);
    idle(4);
    check_eq("pend_live_hold", live0(), 8'hE4);
    do_sync("commit_1b", 8'h1B);
    check_eq("blank1", if0.xbar_blank_out, 1);
    check_eq("blank1_ready", if0.cfg_ready_out, 0);
    check_eq("blank1_pending", if0.pending_out, 0);
    idle(1);
    check_eq("blank2", if0.xbar_blank_out, 1);
    idle(1);
    check_eq("blank3_off", if0.xbar_blank_out, 0);
    check_eq("blank3_ready", if0.cfg_ready_out, 1);

    // Illegal map on instance 0
    if0.cfg_valid_in = 1'b1; if0.cfg_map_in = 8'h0B;
    @(negedge clk_in);
    if0.cfg_valid_in = 1'b0;
    check_eq("bad_err", if0.cfg_err_out, 1);
    check_eq("bad_ready", if0.cfg_ready_out, 1);
    check_eq("bad_pending", if0.pending_out, 0);
    check_eq("bad_live", live0(), 8'h1B);
    idle(1);
    check_eq("bad_err_pulse", if0.cfg_err_out, 0);

    // Same map with fan-out allowed and no blanking (instance 1)
    if1.cfg_valid_in = 1'b1; if1.cfg_map_in = 8'h0B;
    @(negedge clk_in);
    if1.cfg_valid_in = 1'b0;
    check_eq("fan_pending", if1.pending_out, 1);
    check_eq("fan_err", if1.cfg_err_out, 0);
    exp_q.push_back(8'h0B);
    if1.frame_sync_in = 1'b1;
    @(negedge clk_in);
    if1.frame_sync_in = 1'b0;
    sb_check("fan_commit", live1());
    check_eq("fan_noblank", if1.xbar_blank_out, 0);
    check_eq("fan_ready", if1.cfg_ready_out, 1);

    // Back to identity, then rotate
    send_map(8'hE4, 1'b0, 1'b0);
    do_sync("commit_id", 8'hE4);
    idle(2);
    check_eq("id_ready", if0.cfg_ready_out, 1);
    send_rot();
    check_eq("rot_pending", if0.pending_out, 1);
    do_sync("commit_rot", 8'h39);
    idle(2);

    // cfg + rot + frame_sync in one IDLE cycle: cfg wins, no commit yet
    send_map(8'hB1, 1'b1, 1'b1);
    check_eq("mix_pending", if0.pending_out, 1);
    check_eq("mix_live_hold", live0(), 8'h39);
    check_eq("mix_blank", if0.xbar_blank_out, 0);
    idle(2);
    do_sync("commit_mix", 8'hB1);
    idle(2);

    // Abort and frame_sync together: abort wins
    send_map(8'h1B, 1'b0, 1'b0);
    if0.abort_in = 1'b1; if0.frame_sync_in = 1'b1;
    @(negedge clk_in);
    if0.abort_in = 1'b0; if0.frame_sync_in = 1'b0;
    check_eq("abort_pending", if0.pending_out, 0);
    check_eq("abort_ready", if0.cfg_ready_out, 1);
    check_eq("abort_live", live0(), 8'hB1);
    for (int i = 0; i < 3; i++) begin
      check_eq("abort_noblank", if0.xbar_blank_out, 0);
      idle(1);
    end

    // Random maps: legal ones committed, illegal ones flagged
    for (int i = 0; i < 10; i++) begin
      m = 8'($urandom_range(0, 255));
      legal = model_legal(m);
      send_map(m, 1'b0, 1'b0);
      if (legal) begin
        check_eq("rnd_pending", if0.pending_out, 1);
        do_sync("rnd_commit", m);
        idle(2);
      end else begin
        check_eq("rnd_err", if0.cfg_err_out, 1);
        check_eq("rnd_live", live0(), cur_map);
        idle(1);
      end
    end

    // Reset during BLANK
    send_map(8'h1B, 1'b0, 1'b0);
    do_sync("commit_pre_rst", 8'h1B);
    check_eq("pre_rst_blank", if0.xbar_blank_out, 1);
    #2 rst_n_in = 1'b0;
    #1;
    check_eq("arst_sel", live0(), 8'hE4);
    check_eq("arst_blank", if0.xbar_blank_out, 0);
    check_eq("arst_pending", if0.pending_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check_eq("post_rst_ready", if0.cfg_ready_out, 1);
    check_eq("post_rst_sel", live0(), 8'hE4);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
